serial_mag_comparator: RTL and testbench

- Sequential, bit-serial counterpart of the combinational ripple comparator chain.
- The ripple chain resolves LSB->MSB through cascaded cells. This block scans MSB->LSB, one bit per clock, and stops at the first differing bit.
- Operands load in parallel through a valid/ready handshake. The result is held behind a second valid/ready handshake.
- Cascade semantics match the existing cells: result = (a==b) ? eq_in : (b>a).

---
 rtl/serial_cmp_pkg.sv | 15 +
 rtl/bit_compare_cell.sv | 18 +
 rtl/serial_mag_comparator.sv | 137 +++++++++++++
 tb/tb_serial_mag_comparator.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_cmp_pkg.sv
// serial_cmp_pkg
//   Shared types and constants for the bit-serial magnitude comparator.
//   - cmp_state_t   : controller states (IDLE, SCAN, DONE)
//   - DEFAULT_WIDTH : default operand width
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bit_compare_cell.sv
// bit_compare_cell
//   Combinational single-bit comparison of one operand bit pair.
//   Ports:
//     a_bit  (in)  : bit of operand A
//     b_bit  (in)  : bit of operand B
//     differ (out) : bits are different
//     b_gt   (out) : B bit is 1 while A bit is 0
module bit_compare_cell (
  input  logic a_bit,
  input  logic b_bit,
  output logic differ,
  output logic b_gt
);

  assign differ = a_bit ^ b_bit;
  assign b_gt   = ~a_bit & b_bit;

endmodule

// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator
//   Bit-serial magnitude comparator. Operands are accepted in parallel,
//   then scanned MSB->LSB one bit per clock; the scan stops at the first
//   differing bit. Cascade semantics: a_lt_b = (a==b) ? eq_in : (b>a).
//   Ports:
//     clk, rst             : clock, synchronous active-high reset
//     start_valid/ready    : operand handshake (ready only in IDLE)
//     a, b, eq_in          : operands and cascade input, sampled on accept
//     res_valid/res_ready  : result handshake (valid only in DONE)
//     a_lt_b, a_eq_b       : comparison result
//     scan_cycles          : number of SCAN cycles the operation used
//     busy                 : controller not in IDLE
module serial_mag_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             eq_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             a_lt_b,
  output logic             a_eq_b,
  output logic [CW-1:0]    scan_cycles,
  output logic             busy
);

  localparam int IW = $clog2(WIDTH);

  cmp_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             eq_in_q, eq_in_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic [CW-1:0]    cycles_q, cycles_d;

  logic bit_differ;
  logic bit_b_gt;

  // Single comparison cell, fed by the bit pair currently selected by idx.
  bit_compare_cell u_cell (
    .a_bit  (a_q[idx_q]),
    .b_bit  (b_q[idx_q]),
    .differ (bit_differ),
    .b_gt   (bit_b_gt)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    eq_in_d  = eq_in_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    lt_d     = lt_q;
    eq_d     = eq_q;
    cycles_d = cycles_q;

    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d     = a;
          b_d     = b;
          eq_in_d = eq_in;
          idx_d   = IW'(WIDTH - 1);
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_differ) begin
          // When the bits differ, B is larger exactly when its bit is the 1.
          lt_d     = bit_b_gt;
          eq_d     = 1'b0;
          cycles_d = cnt_q + 1'b1;
          state_d  = DONE;
        end else if (idx_q == '0) begin
          // Terminal check happens before any decrement, so idx never wraps.
          lt_d     = eq_in_q;
          eq_d     = 1'b1;
          cycles_d = CW'(WIDTH);
          state_d  = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      eq_in_q  <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      eq_in_q  <= eq_in_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      lt_q     <= lt_d;
      eq_q     <= eq_d;
      cycles_q <= cycles_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign a_lt_b      = lt_q;
  assign a_eq_b      = eq_q;
  assign scan_cycles = cycles_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// tb_serial_mag_comparator
//   Directed self-checking bench for serial_mag_comparator (WIDTH=8).
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_serial_mag_comparator;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_valid = 1'b0;
  logic             start_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             eq_in = 1'b0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic             a_lt_b;
  logic             a_eq_b;
  logic [CW-1:0]    scan_cycles;
  logic             busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_mag_comparator #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .eq_in       (eq_in),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .a_lt_b      (a_lt_b),
    .a_eq_b      (a_eq_b),
    .scan_cycles (scan_cycles),
    .busy        (busy)
  );

  // Drives one operand set from IDLE and waits for res_valid. Returns the
  // number of rising edges from acceptance (inclusive) to res_valid, or -1
  // if the result never shows up; callers compare this value.
  task automatic launch(input logic [7:0] va, input logic [7:0] vb,
                        input logic veq, output int edges);
    @(negedge clk);
    a = va; b = vb; eq_in = veq; start_valid = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start_valid = 1'b0;
    while (!res_valid && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (!res_valid) edges = -1;
  endtask

  // Completes the result handshake; leaves the bench at a falling edge in IDLE.
  task automatic retire();
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (start_ready !== 1'b1) begin n_bad++; $display("FAIL reset_start_ready got %b want 1", start_ready); end
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if ({a_lt_b, a_eq_b} !== 2'b00) begin n_bad++; $display("FAIL reset_result got %b%b want 00", a_lt_b, a_eq_b); end
    n_cmp++; if (scan_cycles !== 4'd0) begin n_bad++; $display("FAIL reset_scan_cycles got %0d want 0", scan_cycles); end
    rst = 1'b0;
    $display("reset: start_ready=%b res_valid=%b busy=%b", start_ready, res_valid, busy);
  endtask

  // Generic directed operation with expected result and latency.
  task automatic test_op(input string name, input logic [7:0] va, input logic [7:0] vb,
                         input logic veq, input logic exp_lt, input logic exp_eq,
                         input int exp_cycles);
    int edges;
    launch(va, vb, veq, edges);
    n_cmp++; if (edges !== exp_cycles + 1) begin n_bad++; $display("FAIL %s_latency got %0d want %0d", name, edges, exp_cycles + 1); end
    n_cmp++; if (a_lt_b !== exp_lt) begin n_bad++; $display("FAIL %s_lt got %b want %b", name, a_lt_b, exp_lt); end
    n_cmp++; if (a_eq_b !== exp_eq) begin n_bad++; $display("FAIL %s_eq got %b want %b", name, a_eq_b, exp_eq); end
    n_cmp++; if (scan_cycles !== CW'(exp_cycles)) begin n_bad++; $display("FAIL %s_cycles got %0d want %0d", name, scan_cycles, exp_cycles); end
    n_cmp++; if (busy !== 1'b1 || start_ready !== 1'b0) begin n_bad++; $display("FAIL %s_done_flags got busy=%b ready=%b want 1/0", name, busy, start_ready); end
    retire();
    n_cmp++; if (res_valid !== 1'b0 || start_ready !== 1'b1) begin n_bad++; $display("FAIL %s_retire got valid=%b ready=%b want 0/1", name, res_valid, start_ready); end
    $display("%s: a=%h b=%h eq_in=%b -> lt=%b eq=%b cycles=%0d edges=%0d", name, va, vb, veq, a_lt_b, a_eq_b, scan_cycles, edges);
  endtask

  task automatic test_backpressure();
    int edges;
    launch(8'h03, 8'h05, 1'b0, edges);
    n_cmp++; if (edges !== 7) begin n_bad++; $display("FAIL bp_latency got %0d want 7", edges); end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        a = 8'hFF; b = 8'h00; start_valid = 1'b1;
      end else begin
        start_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      n_cmp++; if (res_valid !== 1'b1 || a_lt_b !== 1'b1 || a_eq_b !== 1'b0 || scan_cycles !== 4'd6)
        begin n_bad++; $display("FAIL bp_hold%0d got v=%b lt=%b eq=%b cyc=%0d want 1 1 0 6", i, res_valid, a_lt_b, a_eq_b, scan_cycles); end
      n_cmp++; if (start_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready%0d got %b want 0", i, start_ready); end
    end
    start_valid = 1'b0;
    retire();
    n_cmp++; if (start_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL bp_release got ready=%b valid=%b busy=%b want 1 0 0", start_ready, res_valid, busy); end
    // Result registers keep their last value while idle.
    n_cmp++; if (a_lt_b !== 1'b1 || scan_cycles !== 4'd6) begin n_bad++; $display("FAIL bp_idle_hold got lt=%b cyc=%0d want 1 6", a_lt_b, scan_cycles); end
    $display("backpressure: a=03 b=05 held 5 cycles lt=%b cycles=%0d", a_lt_b, scan_cycles);
  endtask

  task automatic test_reset_mid_scan();
    @(negedge clk);
    a = 8'h01; b = 8'h00; eq_in = 1'b0; start_valid = 1'b1;
    @(posedge clk);              // acceptance
    @(negedge clk);              // SCAN cycle 1
    start_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);              // SCAN cycle 2
    @(posedge clk);
    @(negedge clk);              // SCAN cycle 3
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midrst_busy_before got %b want 1", busy); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (start_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL midrst_flags got ready=%b valid=%b busy=%b want 1 0 0", start_ready, res_valid, busy); end
    n_cmp++; if (scan_cycles !== 4'd0 || a_lt_b !== 1'b0 || a_eq_b !== 1'b0) begin n_bad++; $display("FAIL midrst_result got cyc=%0d lt=%b eq=%b want 0 0 0", scan_cycles, a_lt_b, a_eq_b); end
    $display("reset_mid_scan: ready=%b valid=%b busy=%b cycles=%0d", start_ready, res_valid, busy, scan_cycles);
    test_op("after_reset", 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 8);
  endtask

  task automatic test_back_to_back();
    logic [7:0] pa [3];
    logic [7:0] pb [3];
    logic       pe [3];
    logic       exp_lt [3];
    logic       exp_eq [3];
    int         exp_cyc [3];
    int k;
    int idle_cnt;
    int guard;
    pa[0] = 8'hF0; pb[0] = 8'h0F; pe[0] = 1'b0; exp_lt[0] = 1'b0; exp_eq[0] = 1'b0; exp_cyc[0] = 1;
    pa[1] = 8'h0F; pb[1] = 8'hF0; pe[1] = 1'b0; exp_lt[1] = 1'b1; exp_eq[1] = 1'b0; exp_cyc[1] = 1;
    pa[2] = 8'hAA; pb[2] = 8'hAA; pe[2] = 1'b1; exp_lt[2] = 1'b1; exp_eq[2] = 1'b1; exp_cyc[2] = 8;
    k = 0; idle_cnt = 0; guard = 0;
    @(negedge clk);
    a = pa[0]; b = pb[0]; eq_in = pe[0];
    start_valid = 1'b1; res_ready = 1'b1;
    while (k < 3 && guard < 60) begin
      @(posedge clk);
      @(negedge clk);
      guard++;
      if (res_valid) begin
        n_cmp++; if (a_lt_b !== exp_lt[k] || a_eq_b !== exp_eq[k] || scan_cycles !== CW'(exp_cyc[k]))
          begin n_bad++; $display("FAIL b2b_result%0d got lt=%b eq=%b cyc=%0d want %b %b %0d", k, a_lt_b, a_eq_b, scan_cycles, exp_lt[k], exp_eq[k], exp_cyc[k]); end
        if (k > 0) begin
          n_cmp++; if (idle_cnt !== 1) begin n_bad++; $display("FAIL b2b_gap%0d got %0d idle cycles want 1", k, idle_cnt); end
        end
        $display("b2b[%0d]: a=%h b=%h -> lt=%b eq=%b cycles=%0d idle_gap=%0d", k, pa[k], pb[k], a_lt_b, a_eq_b, scan_cycles, idle_cnt);
        k++;
        idle_cnt = 0;
      end else if (start_ready) begin
        idle_cnt++;
        if (k < 3) begin
          a = pa[k]; b = pb[k]; eq_in = pe[k];
        end
      end
    end
    n_cmp++; if (k !== 3) begin n_bad++; $display("FAIL b2b_count got %0d results want 3", k); end
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0; res_ready = 1'b0;
    n_cmp++; if (start_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL b2b_end got ready=%b busy=%b want 1 0", start_ready, busy); end
  endtask

  initial begin
    test_reset();
    test_op("msb_term", 8'h80, 8'h7F, 1'b0, 1'b0, 1'b0, 1);
    test_op("lsb_term", 8'h12, 8'h13, 1'b0, 1'b1, 1'b0, 8);
    test_op("equal_eq1", 8'h5A, 8'h5A, 1'b1, 1'b1, 1'b1, 8);
    test_op("equal_eq0", 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1, 8);
    test_backpressure();
    test_reset_mid_scan();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
